// File: rtl/tablero_color_pkg.sv
// Shared definitions for the 4x4 color board: widths, FSM encoding and the
// (row, col) -> cell index mapping also used by the display path.
package tablero_color_pkg;

    localparam int AW     = 4;
    localparam int DW     = 3;
    localparam int NCELLS = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Column 0 is the leftmost column and row 0 the top row, so top-left is 15.
    function automatic logic [AW-1:0] cell_index(input logic [1:0] row,
                                                 input logic [1:0] col);
        int v;
        v = 15 - 4 * int'(col) - int'(row);
        return AW'(v);
    endfunction

endpackage

// File: rtl/tablero_color_sync_flanco.sv
// Two-flop synchronizer for an asynchronous button, followed by a
// rising-edge detector against a third delayed flop.
module sync_flanco (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic flanco_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign flanco_o = s2_q & ~s3_q;

endmodule

// File: rtl/tablero_color.sv
// 4x4 board of color indices: cursor/color editing from buttons, a 16-cycle
// clear sweep, a combinational display read port and a write mirror.
module tablero_color #(
    parameter int             AW           = tablero_color_pkg::AW,
    parameter int             DW           = tablero_color_pkg::DW,
    parameter logic [DW-1:0]  CLEAR_COLOR  = '0,
    parameter logic [DW-1:0]  CURSOR_COLOR = '1,
    parameter int             BLINK_W      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_color,
    input  logic          btn_clear,
    input  logic [AW-1:0] posicion,
    output logic [DW-1:0] dirColor,
    output logic [AW-1:0] cursor,
    output logic          busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [0:0]    state_dbg
);

    import tablero_color_pkg::*;

    localparam int NC = 1 << AW;

    // Handshake: none; wr_en is a one-cycle strobe, valid with wr_addr/wr_data.
    logic e_up, e_down, e_left, e_right, e_color, e_clear;

    sync_flanco u_sync_up    (.clk_i(clk), .rst_ni(rst), .btn_i(btn_up),    .flanco_o(e_up));
    sync_flanco u_sync_down  (.clk_i(clk), .rst_ni(rst), .btn_i(btn_down),  .flanco_o(e_down));
    sync_flanco u_sync_left  (.clk_i(clk), .rst_ni(rst), .btn_i(btn_left),  .flanco_o(e_left));
    sync_flanco u_sync_right (.clk_i(clk), .rst_ni(rst), .btn_i(btn_right), .flanco_o(e_right));
    sync_flanco u_sync_color (.clk_i(clk), .rst_ni(rst), .btn_i(btn_color), .flanco_o(e_color));
    sync_flanco u_sync_clear (.clk_i(clk), .rst_ni(rst), .btn_i(btn_clear), .flanco_o(e_clear));

    logic [0:0]         state_q, state_d;
    logic [AW-1:0]      sweep_q, sweep_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic [DW-1:0]      cell_q [NC];
    logic [BLINK_W-1:0] blink_q;
    logic               busy_q;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [DW-1:0]      wr_data_q, wr_data_d;

    assign cursor = cell_index(row_q, col_q);

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == ST_CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sweep_q;
            wr_data_d = CLEAR_COLOR;
            sweep_d   = sweep_q + 1'b1;
            if (sweep_q == AW'(NC - 1)) begin
                state_d = ST_IDLE;
            end
        end else begin
            // One action per cycle; lower-priority edges are simply lost.
            if (e_clear) begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end else if (e_color) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cursor;
                wr_data_d = cell_q[cursor] + 1'b1;
            end else if (e_up) begin
                row_d = row_q - 2'd1;
            end else if (e_down) begin
                row_d = row_q + 2'd1;
            end else if (e_left) begin
                col_d = col_q - 2'd1;
            end else if (e_right) begin
                col_d = col_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sweep_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            blink_q   <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NC; i++) begin
                cell_q[i] <= CLEAR_COLOR;
            end
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            row_q     <= row_d;
            col_q     <= col_d;
            blink_q   <= blink_q + 1'b1;
            // busy trails the sweep state by one edge so it covers all 16 writes.
            busy_q    <= (state_q == ST_CLEAR);
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (wr_en_d) begin
                cell_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign dirColor  = (posicion == cursor && blink_q[BLINK_W-1]) ? CURSOR_COLOR
                                                                  : cell_q[posicion];
    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign state_dbg = state_q;

endmodule
